// File: rtl/blowfish128_pkg.sv
// Shared definitions for the streaming Blowfish-128 F-function:
// legal pipeline depths, bit-rotate helpers, S-box lookups and the
// per-stage datapath slices used by both pipeline layouts.
package blowfish128_pkg;

    localparam int DEPTH_SHORT = 3;
    localparam int DEPTH_LONG  = 5;

    // Intermediate payload shapes between stages (tag not included).
    typedef logic [63:0]  split_word_t;   // a..h after the input rotates
    typedef logic [255:0] sbox_word_t;    // S1a,S1b,S1c,S1d,S2e,S2f,S2g,S2h
    typedef logic [191:0] xor_word_t;     // x1,S1c,S1d,x2,S2g,S2h
    typedef logic [127:0] add_word_t;     // t1,S1d,t2,S2h

    function automatic logic [7:0] rotr1_8(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    function automatic logic [31:0] rotr1_32(input logic [31:0] v);
        return {v[0], v[31:1]};
    endfunction

    function automatic logic [31:0] rotl1_32(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

    // S-box 1: byte spread over a word, then a multiplicative mix.
    function automatic logic [31:0] blowfish128_sbox1(input logic [7:0] v);
        logic [31:0] w;
        w = {v, ~v, v ^ 8'h5A, v + 8'h3C};
        return (w * 32'h9E37_79B1) ^ 32'h243F_6A88;
    endfunction

    // S-box 2: different byte spread and mixing constants from S-box 1.
    function automatic logic [31:0] blowfish128_sbox2(input logic [7:0] v);
        logic [31:0] w;
        w = {v ^ 8'hA5, v + 8'h17, ~v, v};
        return (w * 32'h85EB_CA6B) ^ 32'hC2B2_AE35;
    endfunction

    // Split X into bytes and apply the input-side 1-bit rotates.
    function automatic split_word_t bf_split(input logic [63:0] x);
        return {x[63:56], rotr1_8(x[55:48]), x[47:40], rotr1_8(x[39:32]),
                rotr1_8(x[31:24]), x[23:16], rotr1_8(x[15:8]), x[7:0]};
    endfunction

    // S-box lookups with the output-side rotates.
    function automatic sbox_word_t bf_sbox(input split_word_t p);
        return {rotr1_32(blowfish128_sbox1(p[63:56])), blowfish128_sbox1(p[55:48]),
                rotr1_32(blowfish128_sbox1(p[47:40])), blowfish128_sbox1(p[39:32]),
                blowfish128_sbox2(p[31:24]), rotl1_32(blowfish128_sbox2(p[23:16])),
                blowfish128_sbox2(p[15:8]),  rotl1_32(blowfish128_sbox2(p[7:0]))};
    endfunction

    // First XOR of each half; the remaining S-box words pass through.
    function automatic xor_word_t bf_xor(input sbox_word_t s);
        return {s[255:224] ^ s[223:192], s[191:160], s[159:128],
                s[127:96] ^ s[95:64], s[63:32], s[31:0]};
    endfunction

    // Modulo-2^32 add of each half.
    function automatic add_word_t bf_add(input xor_word_t m);
        return {m[191:160] + m[159:128], m[127:96],
                m[95:64] + m[63:32], m[31:0]};
    endfunction

    // Final XOR yields Y.
    function automatic logic [63:0] bf_final(input add_word_t a);
        return {a[127:96] ^ a[95:64], a[63:32] ^ a[31:0]};
    endfunction

endpackage

// File: rtl/blowfish128_pipe_slice.sv
// One valid/ready register stage. The stage loads whenever it is empty or
// its downstream neighbour is taking the current entry, so bubbles collapse
// under backpressure. Flush clears the valid bit only; data is kept.
module blowfish128_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next-state: load on a ready slot, hold while stalled, flush drops valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
        end
        if (in_ready && in_valid) begin
            data_d = in_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Stage registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/blowfish128_ffunc_pipe.sv
// Streaming Blowfish-128 F-function, Y = F(X), one result per clock.
// Each stage is a blowfish128_pipe_slice carrying {tag, partial result};
// the ready chain runs combinationally from OutReady back to InReady.
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; the source holds valid/data until it transfers, ready never
// depends on valid of the same port, and OutValid/Y/OutTag come straight
// from the last stage register so they hold while OutReady is low.
module blowfish128_ffunc_pipe
    import blowfish128_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int PIPE_DEPTH = 5
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [63:0]      X,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [63:0]      Y,
    output logic [TAG_W-1:0] OutTag,
    output logic             Busy
);

    if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
        $error("blowfish128_ffunc_pipe: TAG_W must be in 1..16");
    end

    if (PIPE_DEPTH == DEPTH_LONG) begin : g_deep
        // S0 split/rotate, S1 S-box, S2 first XOR, S3 ADD, S4 second XOR.
        localparam int PW0 = TAG_W + 64;
        localparam int PW1 = TAG_W + 256;
        localparam int PW2 = TAG_W + 192;
        localparam int PW3 = TAG_W + 128;
        localparam int PW4 = TAG_W + 64;

        logic [PW0-1:0] s0_d, s0_q;
        logic [PW1-1:0] s1_d, s1_q;
        logic [PW2-1:0] s2_d, s2_q;
        logic [PW3-1:0] s3_d, s3_q;
        logic [PW4-1:0] s4_d, s4_q;
        logic s0_valid, s1_valid, s2_valid, s3_valid, s4_valid;
        logic s0_ready, s1_ready, s2_ready, s3_ready, s4_ready;

        assign s0_d = {InTag, bf_split(X)};
        assign s1_d = {s0_q[PW0-1 -: TAG_W], bf_sbox(s0_q[63:0])};
        assign s2_d = {s1_q[PW1-1 -: TAG_W], bf_xor(s1_q[255:0])};
        assign s3_d = {s2_q[PW2-1 -: TAG_W], bf_add(s2_q[191:0])};
        assign s4_d = {s3_q[PW3-1 -: TAG_W], bf_final(s3_q[127:0])};

        blowfish128_pipe_slice #(.W(PW0)) u_s0 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(InValid), .in_ready(s0_ready), .in_data(s0_d),
            .out_valid(s0_valid), .out_data(s0_q), .out_ready(s1_ready));
        blowfish128_pipe_slice #(.W(PW1)) u_s1 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(s0_valid), .in_ready(s1_ready), .in_data(s1_d),
            .out_valid(s1_valid), .out_data(s1_q), .out_ready(s2_ready));
        blowfish128_pipe_slice #(.W(PW2)) u_s2 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(s1_valid), .in_ready(s2_ready), .in_data(s2_d),
            .out_valid(s2_valid), .out_data(s2_q), .out_ready(s3_ready));
        blowfish128_pipe_slice #(.W(PW3)) u_s3 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(s2_valid), .in_ready(s3_ready), .in_data(s3_d),
            .out_valid(s3_valid), .out_data(s3_q), .out_ready(s4_ready));
        blowfish128_pipe_slice #(.W(PW4)) u_s4 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(s3_valid), .in_ready(s4_ready), .in_data(s4_d),
            .out_valid(s4_valid), .out_data(s4_q), .out_ready(OutReady));

        assign InReady  = s0_ready;
        assign OutValid = s4_valid;
        assign OutTag   = s4_q[PW4-1 -: TAG_W];
        assign Y        = s4_q[63:0];
        assign Busy     = s0_valid | s1_valid | s2_valid | s3_valid | s4_valid;
    end else if (PIPE_DEPTH == DEPTH_SHORT) begin : g_short
        // S0 split + S-box, S1 first XOR + ADD, S2 second XOR.
        localparam int PW0 = TAG_W + 256;
        localparam int PW1 = TAG_W + 128;
        localparam int PW2 = TAG_W + 64;

        logic [PW0-1:0] s0_d, s0_q;
        logic [PW1-1:0] s1_d, s1_q;
        logic [PW2-1:0] s2_d, s2_q;
        logic s0_valid, s1_valid, s2_valid;
        logic s0_ready, s1_ready, s2_ready;

        assign s0_d = {InTag, bf_sbox(bf_split(X))};
        assign s1_d = {s0_q[PW0-1 -: TAG_W], bf_add(bf_xor(s0_q[255:0]))};
        assign s2_d = {s1_q[PW1-1 -: TAG_W], bf_final(s1_q[127:0])};

        blowfish128_pipe_slice #(.W(PW0)) u_s0 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(InValid), .in_ready(s0_ready), .in_data(s0_d),
            .out_valid(s0_valid), .out_data(s0_q), .out_ready(s1_ready));
        blowfish128_pipe_slice #(.W(PW1)) u_s1 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(s0_valid), .in_ready(s1_ready), .in_data(s1_d),
            .out_valid(s1_valid), .out_data(s1_q), .out_ready(s2_ready));
        blowfish128_pipe_slice #(.W(PW2)) u_s2 (
            .clk(Clk), .rst_n(RstN), .flush(Flush),
            .in_valid(s1_valid), .in_ready(s2_ready), .in_data(s2_d),
            .out_valid(s2_valid), .out_data(s2_q), .out_ready(OutReady));

        assign InReady  = s0_ready;
        assign OutValid = s2_valid;
        assign OutTag   = s2_q[PW2-1 -: TAG_W];
        assign Y        = s2_q[63:0];
        assign Busy     = s0_valid | s1_valid | s2_valid;
    end else begin : g_bad_depth
        $error("blowfish128_ffunc_pipe: PIPE_DEPTH must be 3 or 5");
    end

endmodule

// File: tb/tb_blowfish128_ffunc_pipe.sv
// Bench for blowfish128_ffunc_pipe: a depth-5 instance takes all traffic,
// a depth-3 instance mirrors the unstalled phases. Each instance has its
// own expected queue fed on accepted inputs and drained on outputs.
module tb_blowfish128_ffunc_pipe;

    localparam int TAG_W  = 4;
    localparam int W      = TAG_W + 64;
    localparam int DEPTH  = 5;
    localparam int DEPTH3 = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      x;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      y;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    logic             mirror3;
    logic             in_valid3;
    logic             in_ready3;
    logic             out_valid3;
    logic             out_ready3;
    logic [63:0]      y3;
    logic [TAG_W-1:0] out_tag3;
    logic             busy3;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp3_q[$];
    int n_checks = 0;
    int n_errors = 0;

    assign in_valid3 = in_valid & mirror3;

    // Clock
    always #5 clk = ~clk;

    blowfish128_ffunc_pipe #(.TAG_W(TAG_W), .PIPE_DEPTH(DEPTH)) dut (
        .Clk(clk), .RstN(rst_n), .Flush(flush),
        .InValid(in_valid), .InReady(in_ready), .X(x), .InTag(in_tag),
        .OutValid(out_valid), .OutReady(out_ready), .Y(y), .OutTag(out_tag),
        .Busy(busy));

    blowfish128_ffunc_pipe #(.TAG_W(TAG_W), .PIPE_DEPTH(DEPTH3)) dut3 (
        .Clk(clk), .RstN(rst_n), .Flush(flush),
        .InValid(in_valid3), .InReady(in_ready3), .X(x), .InTag(in_tag),
        .OutValid(out_valid3), .OutReady(out_ready3), .Y(y3), .OutTag(out_tag3),
        .Busy(busy3));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, written directly from the F-function definition.
    function automatic logic [31:0] sb1(input logic [7:0] v);
        logic [31:0] w;
        w = {v, ~v, v ^ 8'h5A, v + 8'h3C};
        return (w * 32'h9E37_79B1) ^ 32'h243F_6A88;
    endfunction

    function automatic logic [31:0] sb2(input logic [7:0] v);
        logic [31:0] w;
        w = {v ^ 8'hA5, v + 8'h17, ~v, v};
        return (w * 32'h85EB_CA6B) ^ 32'hC2B2_AE35;
    endfunction

    function automatic logic [63:0] f_model(input logic [63:0] xv);
        logic [7:0]  a, b, c, d, e, f, g, h;
        logic [31:0] t, s1a, s1b, s1c, s1d, s2e, s2f, s2g, s2h;
        a = xv[63:56]; b = {xv[48], xv[55:49]};
        c = xv[47:40]; d = {xv[32], xv[39:33]};
        e = {xv[24], xv[31:25]}; f = xv[23:16];
        g = {xv[8], xv[15:9]};   h = xv[7:0];
        t = sb1(a); s1a = {t[0], t[31:1]};
        s1b = sb1(b);
        t = sb1(c); s1c = {t[0], t[31:1]};
        s1d = sb1(d);
        s2e = sb2(e);
        t = sb2(f); s2f = {t[30:0], t[31]};
        s2g = sb2(g);
        t = sb2(h); s2h = {t[30:0], t[31]};
        return {((s1a ^ s1b) + s1c) ^ s1d, ((s2e ^ s2f) + s2g) ^ s2h};
    endfunction

    // Scoreboard for the depth-5 instance.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb5_extra", W'(exp_q.size()), W'(1));
                else check("sb5_out", {out_tag, y}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back({in_tag, f_model(x)});
        end
    end

    // Scoreboard for the depth-3 instance.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp3_q.delete();
        end else begin
            if (out_valid3 && out_ready3) begin
                if (exp3_q.size() == 0) check("sb3_extra", W'(exp3_q.size()), W'(1));
                else check("sb3_out", {out_tag3, y3}, exp3_q.pop_front());
            end
            if (in_valid3 && in_ready3) exp3_q.push_back({in_tag, f_model(x)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || exp3_q.size() != 0) && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(tag, W'(exp_q.size() + exp3_q.size()), W'(0));
        step();
    endtask

    // Drive one operand and hold it until the depth-5 instance takes it.
    task automatic send(input logic [63:0] xv, input logic [TAG_W-1:0] tv);
        int c;
        logic took;
        in_valid = 1'b1;
        x        = xv;
        in_tag   = tv;
        took     = 1'b0;
        c        = 0;
        while (!took && c < 100) begin
            @(negedge clk);
            took = in_ready;
            step();
            c++;
        end
        in_valid = 1'b0;
        check("send_timeout", W'(took), W'(1));
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, lat3, cnt, first, last, acc, cyc;
        logic took;
        logic [W-1:0] y_hold;
        logic held;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; x = '0; in_tag = '0;
        out_ready = 1'b1; out_ready3 = 1'b1; mirror3 = 1'b0;
        repeat (3) step();
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_y", W'(y), W'(0));
        check("rst_out_tag", W'(out_tag), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst3_out_valid", W'(out_valid3), W'(0));
        rst_n = 1'b1;
        step();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst3_in_ready", W'(in_ready3), W'(1));

        // Latency of X=0, tag 3 through both depths.
        mirror3 = 1'b1; x = '0; in_tag = 4'h3; in_valid = 1'b1;
        lat = 0; lat3 = 0;
        for (int c = 1; c <= DEPTH + 4; c++) begin
            @(negedge clk);
            if (out_valid && lat == 0) begin
                lat = c - 1;
                check("lat5_tag", W'(out_tag), W'(4'h3));
            end
            if (out_valid3 && lat3 == 0) begin
                lat3 = c - 1;
                check("lat3_tag", W'(out_tag3), W'(4'h3));
            end
            step();
            in_valid = 1'b0;
        end
        check("lat5", W'(lat), W'(DEPTH));
        check("lat3", W'(lat3), W'(DEPTH3));
        wait_drain("lat_drain");

        // 16 back-to-back operands with tags 0..15.
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 16 + DEPTH + 4; c++) begin
            if (c < 16) begin
                in_valid = 1'b1;
                x        = {$urandom, $urandom};
                in_tag   = TAG_W'(c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 16) check("burst_in_ready", W'(in_ready), W'(1));
            if (out_valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            step();
        end
        check("burst_count", W'(cnt), W'(16));
        check("burst_contig", W'(last - first + 1), W'(16));
        wait_drain("burst_drain");
        mirror3 = 1'b0;

        // Stall: fills to DEPTH entries then refuses, output held stable.
        out_ready = 1'b0; in_valid = 1'b1;
        x = {$urandom, $urandom}; in_tag = TAG_W'($urandom_range(0, 15));
        acc = 0; held = 1'b0; y_hold = '0;
        for (int c = 0; c < DEPTH + 6; c++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            if (out_valid && !held) begin
                held   = 1'b1;
                y_hold = {out_tag, y};
            end
            step();
            if (took) begin
                x      = {$urandom, $urandom};
                in_tag = TAG_W'($urandom_range(0, 15));
            end
        end
        check("stall_accepted", W'(acc), W'(DEPTH));
        check("stall_in_ready", W'(in_ready), W'(0));
        check("stall_busy", W'(busy), W'(1));
        check("stall_y_hold", {out_tag, y}, y_hold);
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain("stall_drain");

        // Random valid 50% / ready 30% for 1000 operands.
        acc = 0; cyc = 0; in_valid = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                x        = {$urandom, $urandom};
                in_tag   = TAG_W'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            took = in_valid && in_ready;
            step();
            if (took) begin
                acc++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        check("rand_accepted", W'(acc), W'(1000));
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain("rand_drain");

        // Flush a full pipe together with an input and an output transfer.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send({$urandom, $urandom}, TAG_W'(i));
        end
        check("flush_full", W'(in_ready), W'(0));
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        x = 64'hDEAD_BEEF_0123_4567; in_tag = 4'hE;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", W'(out_valid), W'(0));
        check("flush_busy", W'(busy), W'(0));
        check("flush_in_ready", W'(in_ready), W'(1));
        cnt = 0;
        for (int c = 0; c < DEPTH + 3; c++) begin
            @(negedge clk);
            if (out_valid) cnt++;
            step();
        end
        check("flush_no_ghost", W'(cnt), W'(0));

        // Asynchronous reset with three operands in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send({$urandom, $urandom}, TAG_W'(8 + i));
        end
        repeat (DEPTH) step();
        @(negedge clk);
        check("arst_pre_valid", W'(out_valid), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", W'(out_valid), W'(0));
        check("arst_y", W'(y), W'(0));
        check("arst_out_tag", W'(out_tag), W'(0));
        check("arst_busy", W'(busy), W'(0));
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        check("arst_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 4'hA);
        wait_drain("arst_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
